// File: rtl/branch_ckpt_table_pkg.sv
// Shared types for the branch checkpoint table: default sizing and the
// per-slot snapshot record (RAT, ready bits, ROB tag, free-list head).
package branch_ckpt_table_pkg;

    localparam int CKPT_NUM  = 4;
    localparam int CDB_NUM   = 2;
    localparam int ARCH_REGS = 32;
    localparam int P_REG_NUM = 64;
    localparam int ROB_DEPTH = 32;
    localparam int FL_DEPTH  = 32;
    localparam int PW = $clog2(P_REG_NUM);
    localparam int RW = $clog2(ROB_DEPTH) + 1;
    localparam int FW = $clog2(FL_DEPTH) + 1;

    // Layout of rat matches the flat ARCH_REGS*PW port vectors (reg r at [r*PW +: PW]).
    typedef struct packed {
        logic [ARCH_REGS-1:0][PW-1:0] rat;
        logic [ARCH_REGS-1:0]         rat_valid;
        logic [RW-1:0]                rob_tag;
        logic [FW-1:0]                fl_head;
    } ckpt_entry_t;

endpackage

// File: rtl/ckpt_age_matrix.sv
// Relative-age tracker for checkpoint slots. yng[i][j] is set when slot i
// was allocated after slot j while j was still live.
module ckpt_age_matrix #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_en,
    input  logic [IW-1:0] alloc_id,
    input  logic [N-1:0]  live,
    input  logic [N-1:0]  free_mask,
    input  logic [IW-1:0] query_id,
    output logic [N-1:0]  younger
);
    import branch_ckpt_table_pkg::*;

    logic [N-1:0][N-1:0] yng;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            yng <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    // Freed slots drop out of every relation; a fresh slot is
                    // younger than all survivors and older than nobody.
                    if (free_mask[i] || free_mask[j])
                        yng[i][j] <= 1'b0;
                    else if (alloc_en && alloc_id == IW'(i))
                        yng[i][j] <= live[j];
                    else if (alloc_en && alloc_id == IW'(j))
                        yng[i][j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        younger = '0;
        for (int i = 0; i < N; i++) younger[i] = yng[i][query_id];
    end

endmodule

// File: rtl/branch_ckpt_table.sv
// Branch checkpoint table: snapshots rename state per in-flight branch,
// frees on resolve, squashes younger checkpoints and supplies recovery state.
module branch_ckpt_table #(
    parameter int  CKPT_NUM  = branch_ckpt_table_pkg::CKPT_NUM,
    parameter int  ARCH_REGS = branch_ckpt_table_pkg::ARCH_REGS,
    parameter int  P_REG_NUM = branch_ckpt_table_pkg::P_REG_NUM,
    parameter int  ROB_DEPTH = branch_ckpt_table_pkg::ROB_DEPTH,
    parameter int  FL_DEPTH  = branch_ckpt_table_pkg::FL_DEPTH,
    parameter int  CDB_NUM   = branch_ckpt_table_pkg::CDB_NUM,
    localparam int PW = $clog2(P_REG_NUM),
    localparam int RW = $clog2(ROB_DEPTH) + 1,
    localparam int FW = $clog2(FL_DEPTH) + 1,
    localparam int CW = $clog2(CKPT_NUM),
    localparam int AW = $clog2(ARCH_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_req,
    output logic                    alloc_gnt,
    output logic [CW-1:0]           alloc_id,
    input  logic [ARCH_REGS*PW-1:0] alloc_rat,
    input  logic [ARCH_REGS-1:0]    alloc_rat_valid,
    input  logic [RW-1:0]           alloc_rob_tag,
    input  logic [FW-1:0]           alloc_fl_head,
    output logic                    full,
    output logic [CW:0]             count,
    output logic [CKPT_NUM-1:0]     branch_mask,
    input  logic                    resolve_valid,
    input  logic [CW-1:0]           resolve_id,
    input  logic                    resolve_mispred,
    output logic [CKPT_NUM-1:0]     squash_mask,
    output logic                    recover_valid,
    output logic [ARCH_REGS*PW-1:0] recover_rat,
    output logic [ARCH_REGS-1:0]    recover_rat_valid,
    output logic [RW-1:0]           recover_rob_tail,
    output logic [FW-1:0]           recover_fl_head,
    input  logic [CDB_NUM-1:0]      cdb_valid,
    input  logic [CDB_NUM*AW-1:0]   cdb_rd,
    input  logic [CDB_NUM*PW-1:0]   cdb_pd
);
    import branch_ckpt_table_pkg::*;

    ckpt_entry_t         entry [CKPT_NUM];
    logic [CKPT_NUM-1:0] live, younger, alloc_oh, resolve_oh, free_mask;
    logic                resolve_hit, mispred;

    // Ready bits that any CDB broadcast this cycle would set for a given RAT image.
    function automatic logic [ARCH_REGS-1:0] cdb_ready(input logic [ARCH_REGS-1:0][PW-1:0] rat);
        logic [ARCH_REGS-1:0] rdy;
        rdy = '0;
        for (int k = 0; k < CDB_NUM; k++)
            for (int r = 1; r < ARCH_REGS; r++)
                if (cdb_valid[k] && cdb_rd[k*AW +: AW] == AW'(r) && rat[r] == cdb_pd[k*PW +: PW])
                    rdy[r] = 1'b1;
        return rdy;
    endfunction

    always_comb begin
        alloc_id = '0;
        for (int i = CKPT_NUM - 1; i >= 0; i--)
            if (!live[i]) alloc_id = CW'(i);
        count = '0;
        for (int i = 0; i < CKPT_NUM; i++)
            count = count + (CW+1)'(live[i]);
    end

    assign full        = &live;
    // rst gating keeps the grant quiet while the table is held in reset.
    assign alloc_gnt   = rst & alloc_req & ~full & ~(resolve_valid & resolve_mispred);
    assign alloc_oh    = alloc_gnt ? (CKPT_NUM'(1) << alloc_id) : '0;
    assign branch_mask = live | alloc_oh;

    assign resolve_oh  = CKPT_NUM'(1) << resolve_id;
    assign resolve_hit = resolve_valid & live[resolve_id];
    assign mispred     = resolve_hit & resolve_mispred;
    assign squash_mask = mispred ? (resolve_oh | (younger & live)) : '0;
    assign free_mask   = mispred ? squash_mask : (resolve_hit ? resolve_oh : '0);

    assign recover_valid     = mispred;
    assign recover_rat       = entry[resolve_id].rat;
    assign recover_rat_valid = entry[resolve_id].rat_valid;
    assign recover_rob_tail  = entry[resolve_id].rob_tag + RW'(1);
    assign recover_fl_head   = entry[resolve_id].fl_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live <= '0;
            for (int i = 0; i < CKPT_NUM; i++) entry[i] <= '0;
        end else begin
            live <= (live & ~free_mask) | alloc_oh;
            for (int i = 0; i < CKPT_NUM; i++) begin
                if (alloc_oh[i]) begin
                    entry[i].rat       <= alloc_rat;
                    entry[i].rat_valid <= alloc_rat_valid | cdb_ready(alloc_rat);
                    entry[i].rob_tag   <= alloc_rob_tag;
                    entry[i].fl_head   <= alloc_fl_head;
                end else if (live[i]) begin
                    entry[i].rat_valid <= entry[i].rat_valid | cdb_ready(entry[i].rat);
                end
            end
        end
    end

    ckpt_age_matrix #(.N(CKPT_NUM)) u_age (
        .clk      (clk),
        .rst      (rst),
        .alloc_en (alloc_gnt),
        .alloc_id (alloc_id),
        .live     (live),
        .free_mask(free_mask),
        .query_id (resolve_id),
        .younger  (younger)
    );

    // Resolving a slot that holds no checkpoint indicates an upstream bug.
    a_resolve_live: assert property (@(posedge clk) disable iff (!rst)
        resolve_valid |-> live[resolve_id]);

endmodule

// File: tb/tb_branch_ckpt_table.sv
// Bench for branch_ckpt_table: directed vector table, hand sequences for CDB,
// collision and async reset, then random traffic against a slot-level model.
module tb_branch_ckpt_table;
    localparam int CK = 4, AR = 32, PW = 6, RW = 6, FW = 6, CN = 2, CW = 2, AW = 5;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic              alloc_req, alloc_gnt;
    logic [CW-1:0]     alloc_id;
    logic [AR*PW-1:0]  alloc_rat, recover_rat;
    logic [AR-1:0]     alloc_rat_valid, recover_rat_valid;
    logic [RW-1:0]     alloc_rob_tag, recover_rob_tail;
    logic [FW-1:0]     alloc_fl_head, recover_fl_head;
    logic              full, resolve_valid, resolve_mispred, recover_valid;
    logic [CW:0]       count;
    logic [CK-1:0]     branch_mask, squash_mask;
    logic [CW-1:0]     resolve_id;
    logic [CN-1:0]     cdb_valid;
    logic [CN*AW-1:0]  cdb_rd;
    logic [CN*PW-1:0]  cdb_pd;

    branch_ckpt_table dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_id(alloc_id),
        .alloc_rat(alloc_rat), .alloc_rat_valid(alloc_rat_valid), .alloc_rob_tag(alloc_rob_tag),
        .alloc_fl_head(alloc_fl_head), .full(full), .count(count), .branch_mask(branch_mask),
        .resolve_valid(resolve_valid), .resolve_id(resolve_id), .resolve_mispred(resolve_mispred),
        .squash_mask(squash_mask), .recover_valid(recover_valid), .recover_rat(recover_rat),
        .recover_rat_valid(recover_rat_valid), .recover_rob_tail(recover_rob_tail),
        .recover_fl_head(recover_fl_head), .cdb_valid(cdb_valid), .cdb_rd(cdb_rd), .cdb_pd(cdb_pd)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-slot snapshot plus an allocation sequence number for age.
    bit             mlive [CK];
    int             mseq  [CK];
    int             seqc;
    logic [PW-1:0]  mrat  [CK][AR];
    bit             mrdy  [CK][AR];
    logic [RW-1:0]  mtag  [CK];
    logic [FW-1:0]  mfl   [CK];

    function automatic void model_reset();
        seqc = 0;
        for (int i = 0; i < CK; i++) begin
            mlive[i] = 0; mseq[i] = 0; mtag[i] = '0; mfl[i] = '0;
            for (int r = 0; r < AR; r++) begin mrat[i][r] = '0; mrdy[i][r] = 0; end
        end
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < CK; i++) n += int'(mlive[i]);
        return n;
    endfunction

    function automatic int m_first_free();
        for (int i = 0; i < CK; i++) if (!mlive[i]) return i;
        return 0;
    endfunction

    function automatic bit m_gnt();
        return alloc_req && m_count() < CK && !(resolve_valid && resolve_mispred);
    endfunction

    function automatic logic [CK-1:0] m_squash();
        logic [CK-1:0] s = '0;
        if (resolve_valid && resolve_mispred && mlive[resolve_id])
            for (int j = 0; j < CK; j++)
                if (j == int'(resolve_id) || (mlive[j] && mseq[j] > mseq[resolve_id])) s[j] = 1'b1;
        return s;
    endfunction

    function automatic bit m_cdb_hit(input int r, input logic [PW-1:0] pd);
        for (int k = 0; k < CN; k++)
            if (cdb_valid[k] && r != 0 && int'(cdb_rd[k*AW +: AW]) == r && cdb_pd[k*PW +: PW] == pd)
                return 1;
        return 0;
    endfunction

    function automatic void model_edge();
        logic [CK-1:0] sq;
        bit g;
        int a;
        sq = m_squash(); g = m_gnt(); a = m_first_free();
        for (int i = 0; i < CK; i++)
            if (mlive[i])
                for (int r = 0; r < AR; r++) if (m_cdb_hit(r, mrat[i][r])) mrdy[i][r] = 1;
        if (resolve_valid && mlive[resolve_id]) begin
            if (resolve_mispred) begin
                for (int i = 0; i < CK; i++) if (sq[i]) mlive[i] = 0;
            end else mlive[resolve_id] = 0;
        end
        if (g) begin
            mlive[a] = 1; seqc++; mseq[a] = seqc;
            mtag[a] = alloc_rob_tag; mfl[a] = alloc_fl_head;
            for (int r = 0; r < AR; r++) begin
                mrat[a][r] = alloc_rat[r*PW +: PW];
                mrdy[a][r] = alloc_rat_valid[r] || m_cdb_hit(r, alloc_rat[r*PW +: PW]);
            end
        end
    endfunction

    task automatic compare_all();
        logic [CK-1:0] bm;
        logic [AR*PW-1:0] prat;
        logic [AR-1:0] prdy;
        bm = '0;
        for (int i = 0; i < CK; i++) bm[i] = mlive[i];
        if (m_gnt()) bm[m_first_free()] = 1'b1;
        chk("rnd_gnt", alloc_gnt, m_gnt());
        if (m_gnt()) chk("rnd_id", alloc_id, m_first_free());
        chk("rnd_full", full, m_count() == CK);
        chk("rnd_count", count, m_count());
        chk("rnd_bmask", branch_mask, bm);
        chk("rnd_squash", squash_mask, m_squash());
        chk("rnd_recv", recover_valid, resolve_valid && resolve_mispred && mlive[resolve_id]);
        if (resolve_valid && resolve_mispred && mlive[resolve_id]) begin
            for (int r = 0; r < AR; r++) begin
                prat[r*PW +: PW] = mrat[resolve_id][r];
                prdy[r] = mrdy[resolve_id][r];
            end
            chk("rnd_rrat", recover_rat, prat);
            chk("rnd_rrdy", recover_rat_valid, prdy);
            chk("rnd_rtail", recover_rob_tail, mtag[resolve_id] + RW'(1));
            chk("rnd_rfl", recover_fl_head, mfl[resolve_id]);
        end
    endtask

    task automatic idle_inputs();
        alloc_req = 0; alloc_rat = '0; alloc_rat_valid = '0; alloc_rob_tag = '0; alloc_fl_head = '0;
        resolve_valid = 0; resolve_id = '0; resolve_mispred = 0;
        cdb_valid = '0; cdb_rd = '0; cdb_pd = '0;
    endtask

    task automatic step();
        @(posedge clk); model_edge(); #1;
    endtask

    task automatic do_reset();
        idle_inputs(); rst = 0; model_reset();
        @(posedge clk); #1; rst = 1;
    endtask

    // Mid-cycle combinational peek at a slot's stored ready bits via the recover port.
    task automatic peek(input logic [CW-1:0] id, output logic [AR-1:0] rdy);
        resolve_valid = 1; resolve_mispred = 1; resolve_id = id; #1;
        chk("peek_recv", recover_valid, 1'b1);
        rdy = recover_rat_valid;
        resolve_valid = 0; resolve_mispred = 0; #1;
    endtask

    typedef struct {
        bit rst_b; bit areq; logic [RW-1:0] tag; bit rv; logic [CW-1:0] rid; bit mis;
        bit e_gnt; logic [CW-1:0] e_id; logic [CK-1:0] e_sq; int e_cnt; bit e_full; bit e_rv; logic [RW-1:0] e_tail;
    } vec_t;
    vec_t tbl [17];

    function automatic vec_t mk(bit rb, bit ar, int tg, bit rv, int rid, bit mis,
                                bit eg, int eid, int esq, int ec, bit ef, bit erv, int et);
        vec_t v;
        v.rst_b = rb; v.areq = ar; v.tag = RW'(tg); v.rv = rv; v.rid = CW'(rid); v.mis = mis;
        v.e_gnt = eg; v.e_id = CW'(eid); v.e_sq = CK'(esq); v.e_cnt = ec; v.e_full = ef;
        v.e_rv = erv; v.e_tail = RW'(et);
        return v;
    endfunction

    initial begin
        logic [AR-1:0] rdy;
        int ids [$];
        idle_inputs();
        alloc_req = 1; resolve_valid = 1; resolve_mispred = 1;
        #1;
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_bmask", branch_mask, 0);
        chk("rst_squash", squash_mask, 0);
        chk("rst_gnt", alloc_gnt, 1'b0);
        chk("rst_id", alloc_id, 0);
        chk("rst_recv", recover_valid, 1'b0);
        do_reset();

        //          rb ar tag rv rid mis  gnt id  sq      cnt full rv tail
        tbl[0]  = mk(0, 1, 10, 0, 0, 0,   1, 0, 0,      0, 0,   0, 0);
        tbl[1]  = mk(0, 1, 11, 0, 0, 0,   1, 1, 0,      1, 0,   0, 0);
        tbl[2]  = mk(0, 1, 12, 0, 0, 0,   1, 2, 0,      2, 0,   0, 0);
        tbl[3]  = mk(0, 1, 13, 0, 0, 0,   1, 3, 0,      3, 0,   0, 0);
        tbl[4]  = mk(0, 1, 14, 0, 0, 0,   0, 0, 0,      4, 1,   0, 0);
        tbl[5]  = mk(0, 0, 0,  1, 2, 0,   0, 0, 0,      4, 1,   0, 0);
        tbl[6]  = mk(0, 1, 20, 0, 0, 0,   1, 2, 0,      3, 0,   0, 0);
        tbl[7]  = mk(0, 1, 0,  1, 3, 1,   0, 0, 'b1100, 4, 1,   1, 14);
        tbl[8]  = mk(0, 0, 0,  0, 0, 0,   0, 0, 0,      2, 0,   0, 0);
        tbl[9]  = mk(1, 1, 30, 0, 0, 0,   1, 0, 0,      0, 0,   0, 0);
        tbl[10] = mk(0, 1, 31, 0, 0, 0,   1, 1, 0,      1, 0,   0, 0);
        tbl[11] = mk(0, 1, 63, 0, 0, 0,   1, 2, 0,      2, 0,   0, 0);
        tbl[12] = mk(0, 1, 33, 0, 0, 0,   1, 3, 0,      3, 0,   0, 0);
        tbl[13] = mk(0, 0, 0,  1, 1, 0,   0, 0, 0,      4, 1,   0, 0);
        tbl[14] = mk(0, 1, 40, 0, 0, 0,   1, 1, 0,      3, 0,   0, 0);
        tbl[15] = mk(0, 0, 0,  1, 2, 1,   0, 0, 'b1110, 4, 1,   1, 0);
        tbl[16] = mk(0, 0, 0,  0, 0, 0,   0, 0, 0,      1, 0,   0, 0);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rst_b) do_reset();
            alloc_req = tbl[i].areq; alloc_rob_tag = tbl[i].tag;
            resolve_valid = tbl[i].rv; resolve_id = tbl[i].rid; resolve_mispred = tbl[i].mis;
            #1;
            chk($sformatf("tbl%0d_gnt", i), alloc_gnt, tbl[i].e_gnt);
            if (tbl[i].e_gnt) chk($sformatf("tbl%0d_id", i), alloc_id, tbl[i].e_id);
            chk($sformatf("tbl%0d_squash", i), squash_mask, tbl[i].e_sq);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_full", i), full, tbl[i].e_full);
            chk($sformatf("tbl%0d_recv", i), recover_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_tail", i), recover_rob_tail, tbl[i].e_tail);
            step();
        end

        // CDB wakeup on a stored snapshot, including the rd=0 and wrong-pd cases.
        do_reset();
        alloc_req = 1; alloc_rat[5*PW +: PW] = 6'd17; alloc_rat[0 +: PW] = 6'd17;
        step();
        idle_inputs();
        peek(0, rdy); chk("cdb_init", rdy[5], 1'b0);
        cdb_valid = 2'b01; cdb_rd[0 +: AW] = 5'd5; cdb_pd[0 +: PW] = 6'd18; step();
        idle_inputs(); peek(0, rdy); chk("cdb_wrong_pd", rdy[5], 1'b0);
        cdb_valid = 2'b01; cdb_rd[0 +: AW] = 5'd0; cdb_pd[0 +: PW] = 6'd17; step();
        idle_inputs(); peek(0, rdy); chk("cdb_rd0", rdy[0], 1'b0);
        cdb_valid = 2'b10; cdb_rd[AW +: AW] = 5'd5; cdb_pd[PW +: PW] = 6'd17; step();
        idle_inputs(); peek(0, rdy); chk("cdb_hit", rdy[5], 1'b1);
        // Same-cycle allocation and matching broadcast.
        alloc_req = 1; alloc_rat[7*PW +: PW] = 6'd9;
        cdb_valid = 2'b01; cdb_rd[0 +: AW] = 5'd7; cdb_pd[0 +: PW] = 6'd9;
        #1; chk("byp_id", alloc_id, 1);
        step();
        idle_inputs(); peek(1, rdy); chk("cdb_bypass", rdy[7], 1'b1);

        // Asynchronous reset between edges with three live slots.
        do_reset();
        alloc_req = 1; step(); step(); step();
        resolve_valid = 1; resolve_id = 0; resolve_mispred = 1; #1;
        chk("arst_pre_count", count, 3);
        rst = 0; #1;
        chk("arst_full", full, 1'b0);
        chk("arst_count", count, 0);
        chk("arst_bmask", branch_mask, 0);
        chk("arst_squash", squash_mask, 0);
        chk("arst_gnt", alloc_gnt, 1'b0);
        chk("arst_id", alloc_id, 0);
        chk("arst_recv", recover_valid, 1'b0);
        idle_inputs(); model_reset(); rst = 1;
        step();

        // Random traffic; resolves only target live slots.
        for (int c = 0; c < 400; c++) begin
            alloc_req = ($urandom_range(0, 99) < 60);
            for (int r = 0; r < AR; r++) alloc_rat[r*PW +: PW] = PW'($urandom_range(0, 7));
            alloc_rat_valid = $urandom;
            alloc_rob_tag = RW'($urandom); alloc_fl_head = FW'($urandom);
            ids.delete();
            for (int i = 0; i < CK; i++) if (mlive[i]) ids.push_back(i);
            resolve_valid = (ids.size() > 0) && ($urandom_range(0, 99) < 40);
            resolve_id = (ids.size() > 0) ? CW'(ids[$urandom_range(0, ids.size() - 1)]) : '0;
            resolve_mispred = ($urandom_range(0, 99) < 25);
            cdb_valid = CN'($urandom);
            for (int k = 0; k < CN; k++) begin
                cdb_rd[k*AW +: AW] = AW'($urandom_range(0, 7));
                cdb_pd[k*PW +: PW] = PW'($urandom_range(0, 7));
            end
            #1;
            compare_all();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_ckpt_table.md
BRANCH_CKPT_TABLE -- requirements
Module: branch_ckpt_table

Interface
REQ-001 Parameters (name, default, meaning):
- CKPT_NUM, 4, checkpoint slots; power of two, 2..16.
- ARCH_REGS, 32, architectural registers.
- P_REG_NUM, 64, physical registers; PW = $clog2(P_REG_NUM).
- ROB_DEPTH, 32, ROB tag carries extra wrap bit; RW = $clog2(ROB_DEPTH)+1.
- FL_DEPTH, 32, free-list pointer with wrap bit; FW = $clog2(FL_DEPTH)+1.
- CDB_NUM, 2, CDB broadcast channels; CW = $clog2(CKPT_NUM).
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, reset; asynchronous, active-low.
- alloc_req, in, 1, rename stage has a branch needing a checkpoint.
- alloc_gnt, out, 1, checkpoint taken this cycle.
- alloc_id, out, CW, slot granted; valid when alloc_gnt.
- alloc_rat, in, ARCH_REGS*PW, RAT snapshot.
- alloc_rat_valid, in, ARCH_REGS, RAT ready bits.
- alloc_rob_tag, in, RW, ROB tag of the branch.
- alloc_fl_head, in, FW, free-list head.
- full, out, 1, no free slot.
- count, out, CW+1, live checkpoints.
- branch_mask, out, CKPT_NUM, live slots including this cycle's grant; tags dispatched uops.
- resolve_valid, in, 1, branch resolved.
- resolve_id, in, CW, slot of the resolving branch.
- resolve_mispred, in, 1, misprediction.
- squash_mask, out, CKPT_NUM, slots killed this cycle.
- recover_valid, out, 1, equals resolve_valid & resolve_mispred & slot live.
- recover_rat, recover_rat_valid, recover_rob_tail, recover_fl_head, out, ARCH_REGS*PW / ARCH_REGS / RW / FW, restore state.
- cdb_valid, cdb_rd, cdb_pd, in, CDB_NUM / CDB_NUM*5 / CDB_NUM*PW, writeback broadcasts.

Function
REQ-003 alloc_gnt SHALL be combinational: alloc_req & !full & !(resolve_valid & resolve_mispred).
REQ-004 alloc_id SHALL be the lowest-index free slot. On a grant, the slot SHALL capture all alloc_* inputs at the clock edge and become live.
REQ-005 Age matrix: on allocation, the new slot SHALL be recorded younger than every slot live at that edge.
REQ-006 Correct resolve (resolve_mispred=0) SHALL free only resolve_id at the edge, in any order. squash_mask SHALL be 0.
REQ-007 Mispredict SHALL set squash_mask to resolve_id plus all live slots younger than it (combinational) and free exactly those slots at the edge.
REQ-008 Recover outputs SHALL be combinational reads of slot resolve_id. recover_rob_tail SHALL equal stored tag+1, modulo 2^RW.
REQ-009 For each CDB channel k with cdb_valid[k] and cdb_rd[k]!=0, every live slot whose stored RAT entry for cdb_rd[k] equals cdb_pd[k] SHALL set its ready bit for that register.
REQ-010 Same-cycle bypass: a slot allocated in the same cycle as a matching CDB write SHALL store that ready bit as 1.
REQ-011 full and count SHALL derive from registered state only. A slot freed at edge N SHALL be allocatable from cycle N+1.
REQ-012 A resolve naming a non-live slot SHALL be ignored, with no state change and recover_valid=0. A simulation assertion SHALL fire.
REQ-013 count SHALL never exceed CKPT_NUM. Allocating when full SHALL be impossible by REQ-003.

Reset
REQ-014 While rst is low, all slots SHALL be non-live, the age matrix SHALL be cleared, and stored data SHALL be zeroed.
REQ-015 Reset values: full=0, count=0, branch_mask=0, squash_mask=0, alloc_gnt=0, alloc_id=0, recover_valid=0.
REQ-016 Assertion mid-operation SHALL drop all checkpoints immediately, without waiting for a clock edge.

Structure
REQ-017 The shared types package SHALL hold CKPT_NUM, CDB_NUM and a ckpt_entry_t struct (rat, rat_valid, rob_tag, fl_head).
REQ-018 Age tracking SHALL be a sub-module, ckpt_age_matrix: alloc/free inputs, younger-than query output.

Verification
REQ-019 Scenario: fill. Four allocations -> ids 0,1,2,3; full=1, count=4; fifth alloc_req -> alloc_gnt=0.
REQ-020 Scenario: out-of-order free. Resolve id2 correct -> next cycle count=3; next alloc -> id 2, marked youngest.
REQ-021 Scenario: mispredict. Allocate 0,1,2,3 in that order, free 1, allocate 1 (now youngest), mispredict id2 -> squash_mask=4'b1110, count=1; recover_rob_tail = tag(id2)+1.
REQ-022 Scenario: CDB. Slot 0 holds rd=5 -> p17 not ready; cdb rd=5, pd=17 -> ready bit set. rd=0, or pd=18 -> no change.
REQ-023 Scenario: collisions. Same-cycle allocation and matching CDB -> stored ready bit=1. Same-cycle alloc_req and mispredict -> alloc_gnt=0.
REQ-024 Scenario: reset. Deassert-then-assert rst between clock edges with 3 live slots -> all outputs at REQ-015 values without a clock edge.
